// File: rtl/ac97_pkg.sv
// ac97_pkg
// Shared AC-link frame geometry, field bit windows, tag bit positions and the
// frame tracker state type for the sdata_in receiver.
// Ports: none (package).
package ac97_pkg;

  localparam int FRAME_BITS  = 256;
  localparam int SLOT0_BITS  = 16;
  localparam int SLOT_BITS   = 20;

  localparam int SLOT1_START = 16;
  localparam int SLOT2_START = 36;
  localparam int SLOT3_START = 56;
  localparam int SLOT4_START = 76;

  // Bit-counter windows for each captured field (inclusive).
  localparam logic [7:0] LAST_BIT    = 8'(FRAME_BITS - 1);
  localparam logic [7:0] TAG_LAST    = 8'(SLOT0_BITS - 1);
  localparam logic [7:0] ADDR_FIRST  = 8'(SLOT1_START + 1);
  localparam logic [7:0] ADDR_LAST   = 8'(SLOT1_START + 7);
  localparam logic [7:0] DATA_FIRST  = 8'(SLOT2_START);
  localparam logic [7:0] DATA_LAST   = 8'(SLOT2_START + 15);
  localparam logic [7:0] LEFT_FIRST  = 8'(SLOT3_START);
  localparam logic [7:0] LEFT_LAST   = 8'(SLOT3_START + SLOT_BITS - 1);
  localparam logic [7:0] RIGHT_FIRST = 8'(SLOT4_START);
  localparam logic [7:0] RIGHT_LAST  = 8'(SLOT4_START + SLOT_BITS - 1);

  localparam int TAG_READY_BIT = 15;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } trk_state_e;

  // Tag bit carrying the valid flag of slot n (1..12).
  function automatic int tag_slot_bit(input int slot);
    return SLOT0_BITS - 1 - slot;
  endfunction

  function automatic logic field_hit(input logic [7:0] cnt,
                                     input logic [7:0] lo,
                                     input logic [7:0] hi);
    return (cnt >= lo) && (cnt <= hi);
  endfunction

endpackage

// File: rtl/ac97_frame_tracker.sv
// ac97_frame_tracker
// Frame alignment from sync: bit counter, lock counter and the HUNT/ACQUIRE/
// LOCKED state machine.
//
// state   | meaning
// HUNT    | no alignment, waiting for any sync rise
// ACQUIRE | counting frames, checking sync spacing until LOCK_FRAMES good rises
// LOCKED  | aligned; frames are deliverable
//
// Ports:
//   bit_clk, reset_b   clock / async active-low reset
//   sync               frame sync
//   bit_cnt            index of the bit sampled on the current edge
//   in_locked_frame    current frame started (bit 0) while LOCKED
//   frame_end          combinational: expected sync rise at bit 255 while LOCKED
//   sync_error         registered one-cycle pulse on misplaced/missing sync
//   locked             registered, 1 while LOCKED
module ac97_frame_tracker
  import ac97_pkg::*;
#(
  parameter int LOCK_FRAMES = 2
) (
  input  logic       bit_clk,
  input  logic       reset_b,
  input  logic       sync,
  output logic [7:0] bit_cnt,
  output logic       in_locked_frame,
  output logic       frame_end,
  output logic       sync_error,
  output logic       locked
);

  localparam logic [7:0] LOCK_TARGET = 8'(LOCK_FRAMES);

  trk_state_e state;
  logic       sync_q;
  logic [7:0] lock_cnt;
  logic       sync_rise;
  logic       at_last;

  assign sync_rise = sync & ~sync_q;
  assign at_last   = (bit_cnt == LAST_BIT);
  assign frame_end = (state == LOCKED) && at_last && sync_rise;

  always_ff @(posedge bit_clk or negedge reset_b) begin
    if (!reset_b) begin
      state           <= HUNT;
      sync_q          <= 1'b0;
      bit_cnt         <= 8'd0;
      lock_cnt        <= 8'd0;
      in_locked_frame <= 1'b0;
      sync_error      <= 1'b0;
      locked          <= 1'b0;
    end else begin
      sync_q     <= sync;
      sync_error <= 1'b0;
      bit_cnt    <= bit_cnt + 8'd1;
      if (bit_cnt == 8'd0)
        in_locked_frame <= (state == LOCKED);

      case (state)
        HUNT: begin
          bit_cnt         <= 8'd0;
          in_locked_frame <= 1'b0;
          if (sync_rise) begin
            state    <= ACQUIRE;
            lock_cnt <= 8'd0;
          end
        end

        ACQUIRE: begin
          if (at_last) begin
            if (sync_rise) begin
              if (lock_cnt + 8'd1 >= LOCK_TARGET) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                lock_cnt <= 8'd0;
              end else begin
                lock_cnt <= lock_cnt + 8'd1;
              end
            end else begin
              state    <= HUNT;
              bit_cnt  <= 8'd0;
              lock_cnt <= 8'd0;
            end
          end else if (sync_rise) begin
            sync_error <= 1'b1;
            bit_cnt    <= 8'd0;
            lock_cnt   <= 8'd0;
          end
        end

        LOCKED: begin
          if (at_last) begin
            if (!sync_rise) begin
              sync_error      <= 1'b1;
              state           <= HUNT;
              locked          <= 1'b0;
              bit_cnt         <= 8'd0;
              in_locked_frame <= 1'b0;
            end
          end else if (sync_rise) begin
            // Early sync: abandon the partial frame and re-qualify spacing.
            sync_error      <= 1'b1;
            state           <= ACQUIRE;
            locked          <= 1'b0;
            bit_cnt         <= 8'd0;
            lock_cnt        <= 8'd0;
            in_locked_frame <= 1'b0;
          end
        end

        default: begin
          state  <= HUNT;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ac97_sdata_in_receiver.sv
// ac97_sdata_in_receiver
// AC-link sdata_in deserializer: shifts slot 0 tag, status address/data and
// PCM left/right into shadow registers and copies them to the outputs when a
// locked frame completes with a correctly placed sync.
//
// Ports:
//   bit_clk, reset_b         codec bit clock / async active-low reset
//   sync, sdata_in           frame sync and serial data (MSB first)
//   locked                   frame alignment established
//   codec_ready, slot_valid  tag of last delivered frame (slot_valid[n-1] = slot n)
//   status_addr/status_data  slot 1 / slot 2 status fields
//   pcm_left/pcm_right       slot 3 / slot 4, MSB-aligned to PCM_WIDTH
//   frame_done, status_valid, pcm_valid, sync_error   one-cycle pulses
module ac97_sdata_in_receiver
  import ac97_pkg::*;
#(
  parameter int PCM_WIDTH   = 20,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                 bit_clk,
  input  logic                 reset_b,
  input  logic                 sync,
  input  logic                 sdata_in,
  output logic                 locked,
  output logic                 codec_ready,
  output logic [11:0]          slot_valid,
  output logic [6:0]           status_addr,
  output logic [15:0]          status_data,
  output logic [PCM_WIDTH-1:0] pcm_left,
  output logic [PCM_WIDTH-1:0] pcm_right,
  output logic                 frame_done,
  output logic                 status_valid,
  output logic                 pcm_valid,
  output logic                 sync_error
);

  logic [7:0]  bit_cnt;
  logic        in_locked_frame;
  logic        frame_end;
  logic        deliver;

  logic [15:0] tag_sh;
  logic [6:0]  addr_sh;
  logic [15:0] data_sh;
  logic [19:0] left_sh;
  logic [19:0] right_sh;
  logic [11:0] tag_slots;
  logic        status_ok;
  logic        pcm_ok;

  ac97_frame_tracker #(
    .LOCK_FRAMES (LOCK_FRAMES)
  ) u_tracker (
    .bit_clk         (bit_clk),
    .reset_b         (reset_b),
    .sync            (sync),
    .bit_cnt         (bit_cnt),
    .in_locked_frame (in_locked_frame),
    .frame_end       (frame_end),
    .sync_error      (sync_error),
    .locked          (locked)
  );

  assign deliver = frame_end & in_locked_frame;

  // Tag bit 14 is slot 1, so slot_valid is the tag slice in reversed order.
  always_comb begin
    tag_slots = '0;
    for (int n = 1; n <= 12; n++)
      tag_slots[n-1] = tag_sh[tag_slot_bit(n)];
  end

  assign status_ok = tag_sh[TAG_READY_BIT] & tag_slots[0] & tag_slots[1];
  assign pcm_ok    = tag_sh[TAG_READY_BIT] & tag_slots[2] & tag_slots[3];

  always_ff @(posedge bit_clk or negedge reset_b) begin
    if (!reset_b) begin
      tag_sh   <= '0;
      addr_sh  <= '0;
      data_sh  <= '0;
      left_sh  <= '0;
      right_sh <= '0;
    end else begin
      if (bit_cnt <= TAG_LAST)
        tag_sh <= {tag_sh[14:0], sdata_in};
      if (field_hit(bit_cnt, ADDR_FIRST, ADDR_LAST))
        addr_sh <= {addr_sh[5:0], sdata_in};
      if (field_hit(bit_cnt, DATA_FIRST, DATA_LAST))
        data_sh <= {data_sh[14:0], sdata_in};
      if (field_hit(bit_cnt, LEFT_FIRST, LEFT_LAST))
        left_sh <= {left_sh[18:0], sdata_in};
      if (field_hit(bit_cnt, RIGHT_FIRST, RIGHT_LAST))
        right_sh <= {right_sh[18:0], sdata_in};
    end
  end

  always_ff @(posedge bit_clk or negedge reset_b) begin
    if (!reset_b) begin
      codec_ready  <= 1'b0;
      slot_valid   <= '0;
      status_addr  <= '0;
      status_data  <= '0;
      pcm_left     <= '0;
      pcm_right    <= '0;
      frame_done   <= 1'b0;
      status_valid <= 1'b0;
      pcm_valid    <= 1'b0;
    end else begin
      frame_done   <= deliver;
      status_valid <= deliver & status_ok;
      pcm_valid    <= deliver & pcm_ok;
      if (deliver) begin
        codec_ready <= tag_sh[TAG_READY_BIT];
        slot_valid  <= tag_slots;
        if (status_ok) begin
          status_addr <= addr_sh;
          status_data <= data_sh;
        end
        if (pcm_ok) begin
          pcm_left  <= left_sh[SLOT_BITS-1 -: PCM_WIDTH];
          pcm_right <= right_sh[SLOT_BITS-1 -: PCM_WIDTH];
        end
      end
    end
  end

endmodule

// File: doc/ac97_sdata_in_receiver.md
Name: ac97_sdata_in_receiver

Overview:
- Controller-side AC-link input deserializer for the frames the codec drives on sdata_in.
- It is the counterpart of the frame transmitter that drives sync and sdata_out.
- It tracks frame alignment from sync, decodes the slot 0 tag, captures the status address and data (slots 1–2) and the PCM capture samples (slots 3–4), and presents them as registered outputs with one-cycle valid pulses.
- It runs entirely in the bit_clk domain; crossing into the system_clock domain is done downstream.

Parameters:
- PCM_WIDTH, default 20: width of pcm_left/pcm_right. Keeps the MSBs of each 20-bit slot; legal range 1..20.
- LOCK_FRAMES, default 2: number of consecutive correctly spaced sync rises required before entering LOCKED.

Ports:
- bit_clk  in  1  AC-link bit clock, supplied by the codec; the only clock, rising edge.
- reset_b  in  1  asynchronous, active-low reset.
- sync  in  1  frame sync as driven by the controller.
- sdata_in  in  1  serial data from the codec, MSB first.
- locked  out  1  frame alignment established.
- codec_ready  out  1  slot 0 bit 15 of the last delivered frame.
- slot_valid  out  12  tag bits 14..3 of the last delivered frame; slot_valid[n-1] = slot n valid.
- status_addr  out  7  slot 1 bits 18:12.
- status_data  out  16  slot 2 bits 19:4.
- pcm_left  out  PCM_WIDTH  slot 3, MSB-aligned.
- pcm_right  out  PCM_WIDTH  slot 4, MSB-aligned.
- frame_done  out  1  one-cycle pulse for each delivered frame.
- status_valid  out  1  one-cycle pulse; status_addr/status_data updated this frame.
- pcm_valid  out  1  one-cycle pulse; pcm_left/pcm_right updated this frame.
- sync_error  out  1  one-cycle pulse when sync placement is wrong.

Behaviour:
- Reset: every output is 0, state is HUNT, bit counter is 0, lock count is 0. Reset is honoured mid-frame; any partial frame is discarded.
- sync is registered into sync_q. A sync rise is an edge where sync=1 and sync_q=0.
- Frame timing:
  - Bit index 0 is the sdata_in sample taken on the first edge after the edge that detects a sync rise.
  - The 8-bit bit_cnt runs 0..255 and wraps.
  - The sample of bit 255 falls on the same edge as the next expected sync rise.
- Bit map, MSB first:
  - Slot 0 occupies indices 0..15 (tag[15-i]).
  - Slot n (n = 1..12) occupies indices 16+20(n-1) .. 35+20(n-1).
  - status_addr = slot 1 indices 17..23.
  - status_data = slot 2 indices 36..51.
  - pcm_left = slot 3 indices 56..75.
  - pcm_right = slot 4 indices 76..95.
- Data is shifted into per-field shadow registers. Shadows are copied to the outputs only at delivery.
- States:
  - HUNT: on a sync rise, go to ACQUIRE, clear bit_cnt, clear lock count.
  - ACQUIRE:
    - A sync rise at bit 255 increments the lock count; on reaching LOCK_FRAMES, go to LOCKED.
    - A sync rise at any other index pulses sync_error, restarts bit_cnt and clears the lock count.
    - No rise at bit 255 goes to HUNT.
  - LOCKED:
    - A sync rise at bit 255 is normal.
    - A sync rise at any other index pulses sync_error, drops to ACQUIRE, restarts bit_cnt, and does not deliver the partial frame.
    - No rise at bit 255 pulses sync_error and goes to HUNT.
- locked is 1 exactly while the state is LOCKED (registered).
- Delivery:
  - A frame is delivered only if the state was LOCKED when its bit 0 was sampled and it completes with the expected sync rise at bit 255.
  - On the edge that samples bit 255: codec_ready and slot_valid update, and frame_done is 1 for the following cycle.
  - If codec_ready and tag slots 1 and 2 are set: status_addr/status_data update and status_valid pulses.
  - If codec_ready and tag slots 3 and 4 are set: pcm_left/pcm_right update and pcm_valid pulses.
  - Otherwise the corresponding output registers hold their values.
- Latency: all outputs update on the bit 255 edge. Pulses never last more than one cycle.
- Simultaneous events:
  - A rise at bit 255 with a fault in the same edge cannot occur.
  - A missing sync takes priority over delivery: no frame_done is produced.

Decomposition:
- Package ac97_pkg holds:
  - constants FRAME_BITS=256, SLOT0_BITS=16, SLOT_BITS=20;
  - slot start indices (SLOT1_START=16, SLOT2_START=36, SLOT3_START=56, SLOT4_START=76);
  - tag bit positions;
  - the state enum {HUNT, ACQUIRE, LOCKED}.
- One sub-module, ac97_frame_tracker, holds sync_q, bit_cnt, the lock counter and the FSM. It outputs bit_cnt, in_locked_frame, frame_end and sync_error. The top level does the field capture.

Test Plan:
- Reset: assert reset_b=0 at bit 100 of a locked frame → all outputs 0 immediately; locked=0; no frame_done after release until re-locked.
- Lock (LOCK_FRAMES=2): sync every 256 bits → locked=1 after the 2nd interval. The first locked frame has tag 16'h9800, slot 3 20'hABCDE, slot 4 20'h12345 → frame_done=1, pcm_valid=1, pcm_left=20'hABCDE, pcm_right=20'h12345, status_valid=0.
- Status: tag 16'hE000, slot 1 addr 7'h26, slot 2 data 16'h000F → status_valid=1, status_addr=7'h26, status_data=16'h000F; pcm outputs held.
- Early sync: sync rise at bit 100 while LOCKED → sync_error pulse, no frame_done, locked=0; re-lock after 2 good intervals.
- Missing sync: no rise at bit 255 → sync_error pulse, state HUNT, locked=0, no frame_done.
- Codec not ready: tag 16'h1800 → frame_done=1, codec_ready=0, pcm_valid=0, pcm_left/pcm_right unchanged.
